// File: rtl/countdown_display.sv
//==============================================================================
// Module      : countdown_display
// Description : Two-digit multiplexed 7-segment front end for a countdown
//               timer with per-frame snapshot, blanked leading zero, paused
//               dot and sticky expiry flag. Optional macro BLINK_ON_EXPIRE_EN
//               blinks the display while expired.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module countdown_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clock_out,
    input  logic       reset_n,
    input  logic [4:0] countdown,
    input  logic       running,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       expired
);

    localparam int TICK_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(REFRESH_DIV - 1);
    localparam logic [6:0] c_seg_blank = 7'h7F;
    localparam logic [3:0] c_an_off    = 4'hF;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              sel_q, sel_d;
    logic [4:0]        value_q, value_d;
    logic              armed_q, armed_d;
    logic              expired_q, expired_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic              dp_q, dp_d;

    logic              w_frame_start;
    logic              w_tick_wrap;
    logic [1:0]        w_tens;
    logic [4:0]        w_tens_sub;
    logic [3:0]        w_ones;
    logic              w_blank;

    always_comb begin
        w_tick_wrap   = (tick_cnt_q == c_tick_last);
        w_frame_start = (tick_cnt_q == '0) && !sel_q;
        tick_cnt_d    = w_tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
        sel_d         = w_tick_wrap ? ~sel_q : sel_q;
        value_d       = w_frame_start ? countdown : value_q;
    end

    // Expiry uses the freshly loaded value so the flag moves with the snapshot.
    always_comb begin
        armed_d   = armed_q;
        expired_d = expired_q;
        if (w_frame_start) begin
            if (countdown != 5'd0) begin
                armed_d   = 1'b1;
                expired_d = 1'b0;
            end else if (armed_q) begin
                expired_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (value_q >= 5'd30) begin
            w_tens     = 2'd3;
            w_tens_sub = 5'd30;
        end else if (value_q >= 5'd20) begin
            w_tens     = 2'd2;
            w_tens_sub = 5'd20;
        end else if (value_q >= 5'd10) begin
            w_tens     = 2'd1;
            w_tens_sub = 5'd10;
        end else begin
            w_tens     = 2'd0;
            w_tens_sub = 5'd0;
        end
        w_ones = 4'(value_q - w_tens_sub);
    end

`ifdef BLINK_ON_EXPIRE_EN
    localparam int BLINK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    // Cleared whenever the flag drops so a new expiry starts with a lit half.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!expired_d) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (w_frame_start && expired_q) begin
            if (blink_cnt_q == c_blink_last) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clock_out or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign w_blank = phase_q;
`else
    // No blink hardware; a non-positive frame count simply keeps the display dark.
    assign w_blank = (BLINK_FRAMES < 1);
`endif

    always_comb begin
        if (!sel_q) begin
            an_d  = 4'b1110;
            seg_d = enc(w_ones);
        end else begin
            an_d  = 4'b1101;
            seg_d = (w_tens == 2'd0) ? c_seg_blank : enc({2'b00, w_tens});
        end
        dp_d = !(!sel_q && !running && !expired_q);
        if (w_blank) begin
            seg_d = c_seg_blank;
            an_d  = c_an_off;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clock_out or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            sel_q      <= 1'b0;
            value_q    <= 5'd0;
            armed_q    <= 1'b0;
            expired_q  <= 1'b0;
            seg_q      <= c_seg_blank;
            an_q       <= c_an_off;
            dp_q       <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sel_q      <= sel_d;
            value_q    <= value_d;
            armed_q    <= armed_d;
            expired_q  <= expired_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;
    assign expired = expired_q;

endmodule

`default_nettype wire
